simon_key_expander: RTL

- Controller and round-key store for the SIMON 64/96 key schedule.
- Accepts a 96-bit master key on a start handshake and sequences one keySchedule datapath instance, one round key per cycle, to produce all 42 round keys.
- Keeps the rotating z-constant register, feeding back shiftZ each round.
- Holds the round keys in an internal buffer with a registered read port, which the round-function sequencer uses to fetch key i for round i.

---
 rtl/simon_key_expander.sv | 120 ++++++++++++
 1 files changed

// File: rtl/simon_key_expander.sv
// SIMON 64/96 key schedule: sequences one round-key datapath to fill a 42-entry
// round-key buffer, exposing a registered read port for the round sequencer.

module simon_key_schedule #(
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] round_key_minus3,
    input  logic [WORD-1:0] round_key_minus1,
    input  logic [61:0]     const_seq_z,
    input  logic [WORD-1:0] seq_c,
    output logic [WORD-1:0] round_key,
    output logic [61:0]     shift_z
);
    logic [WORD-1:0] ror3;
    logic [WORD-1:0] mix;

    // The z bit in use is always the MSB; rotating left presents the next one.
    always_comb begin
        ror3      = {round_key_minus1[2:0], round_key_minus1[WORD-1:3]};
        mix       = ror3 ^ {ror3[0], ror3[WORD-1:1]};
        round_key = round_key_minus3 ^ seq_c ^ mix ^ {{(WORD-1){1'b0}}, const_seq_z[61]};
        shift_z   = {const_seq_z[60:0], const_seq_z[61]};
    end
endmodule

module simon_key_expander #(
    parameter int              N_ROUNDS = 42,
    parameter int              WORD     = 32,
    parameter logic [61:0]     Z_INIT   = 62'b10101111011100000011010010011000101000010001111110010110110011,
    parameter logic [WORD-1:0] C_CONST  = 32'hfffffffc
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3*WORD-1:0] key,
    output logic              busy,
    output logic              done,
    output logic [5:0]        rk_count,
    input  logic [5:0]        rd_addr,
    output logic [WORD-1:0]   rd_data,
    output logic              rd_valid
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [5:0] LAST_IDX  = 6'(N_ROUNDS - 1);

    logic [1:0]      state;
    logic [5:0]      idx;
    logic [61:0]     z_reg;
    logic [WORD-1:0] rk [0:N_ROUNDS-1];
    logic            accept;
    logic            expanding;
    logic [WORD-1:0] round_key;
    logic [61:0]     shift_z;

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign expanding = (state == ST_EXPAND);
    assign busy      = expanding;
    assign done      = (state == ST_DONE);
    // idx doubles as the valid-entry count: entries below it are always written.
    assign rk_count  = idx;

    simon_key_schedule #(.WORD(WORD)) u_key_schedule (
        .round_key_minus3 (rk[idx - 6'd3]),
        .round_key_minus1 (rk[idx - 6'd1]),
        .const_seq_z      (z_reg),
        .seq_c            (C_CONST),
        .round_key        (round_key),
        .shift_z          (shift_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            z_reg <= Z_INIT;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_EXPAND;
                        idx   <= 6'd3;
                        z_reg <= Z_INIT;
                    end
                end
                ST_EXPAND: begin
                    idx   <= idx + 6'd1;
                    z_reg <= shift_z;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so the store has no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rk[0] <= key[WORD-1:0];
            rk[1] <= key[2*WORD-1:WORD];
            rk[2] <= key[3*WORD-1:2*WORD];
        end else if (expanding) begin
            rk[idx] <= round_key;
        end
    end

    // Compares against the pre-edge count, so a same-edge write reads as invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= (rd_addr < idx);
            rd_data  <= (rd_addr < idx) ? rk[rd_addr] : '0;
        end
    end
endmodule
